// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'b00,
    SEL_BR   = 2'b01,
    SEL_JAL  = 2'b10,
    SEL_JALR = 2'b11
  } next_pc_sel_e;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// In-order buffer of fetched {pc, inst} entries; clear wins over push/pop and empties it.
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifu_fetch_unit.sv
// Fetch stage: PC, imem requests under a credit limit, fetch buffer, decode redirects.
// Optional IFU_PERF_CNT_EN adds fetched/dropped counters.
module ifu_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FB_DEPTH     = 2
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [DataWidth-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [DataWidth-1:0] imem_rsp_data,
  input  logic [1:0]           idu_next_pc_sel,
  input  logic                 idu_branch,
  input  logic                 idu_flush,
  input  logic [DataWidth-1:0] idu_branch_addr,
  input  logic [DataWidth-1:0] idu_jal_addr,
  input  logic [DataWidth-1:0] idu_jalr_addr,
  input  logic [1:0]           hazard_stall,
  output logic [DataWidth-1:0] ifu_fetch_inst,
  output logic [DataWidth-1:0] ifu_pc,
  output logic                 ifu_stall
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]          ifu_perf_fetched,
  output logic [31:0]          ifu_perf_dropped
`endif
);

  localparam int unsigned CW  = $clog2(FB_DEPTH + 1);
  localparam int unsigned QAW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;

  fetch_state_e         state;
  logic [DataWidth-1:0] fetch_pc;
  logic [CW-1:0]        outstanding, outstanding_nxt, drop_cnt, drop_nxt, fifo_count;
  logic [DataWidth-1:0] pc_q [FB_DEPTH];
  logic [QAW-1:0]       pq_wr, pq_rd;
  fetch_entry_t         head, push_entry;
  logic                 fifo_empty, redirect, credit_ok, accept, rsp_drop, push, pop;
  logic [DataWidth-1:0] raw_target, target;

  assign redirect  = idu_flush && !fifo_empty;
  assign credit_ok = ((CW+1)'(outstanding) + (CW+1)'(fifo_count)) < (CW+1)'(FB_DEPTH);

  assign imem_req_valid = !brq_rst && !redirect && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Every in-flight response at a redirect is stale, so drop_cnt tracks outstanding.
  assign rsp_drop        = imem_rsp_valid && (redirect || state == DRAIN);
  assign push            = imem_rsp_valid && !rsp_drop;
  assign pop             = !fifo_empty && (hazard_stall == '0 || idu_flush);
  assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect) drop_nxt = outstanding_nxt;
    else if (imem_rsp_valid && state == DRAIN) drop_nxt = drop_cnt - 1'b1;
  end

  // Flush without a taken control transfer restarts just after the consumed head.
  always_comb begin
    raw_target = head.pc + 32'd4;
    case (next_pc_sel_e'(idu_next_pc_sel))
      SEL_BR:   if (idu_branch) raw_target = idu_branch_addr;
      SEL_JAL:  raw_target = idu_jal_addr;
      SEL_JALR: raw_target = idu_jalr_addr;
      default:  ;
    endcase
    target = word_align(raw_target);
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
    end else begin
      state       <= (drop_nxt != '0) ? DRAIN : FETCH;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_nxt;
      if (redirect)    fetch_pc <= target;
      else if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (accept)         pq_wr <= (pq_wr == QAW'(FB_DEPTH - 1)) ? '0 : pq_wr + 1'b1;
      if (imem_rsp_valid) pq_rd <= (pq_rd == QAW'(FB_DEPTH - 1)) ? '0 : pq_rd + 1'b1;
    end
  end

  always_ff @(posedge brq_clk) begin
    if (accept) pc_q[pq_wr] <= fetch_pc;
  end

  assign push_entry = '{pc: pc_q[pq_rd], inst: imem_rsp_data};

  ifu_fetch_fifo #(
    .DEPTH(FB_DEPTH)
  ) u_fetch_fifo (
    .clk  (brq_clk),
    .rst  (brq_rst),
    .push (push),
    .pop  (pop),
    .clear(redirect),
    .wdata(push_entry),
    .rdata(head),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign ifu_fetch_inst = fifo_empty ? NOP_INSN : head.inst;
  assign ifu_pc         = fifo_empty ? '0 : head.pc;
  assign ifu_stall      = fifo_empty;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      ifu_perf_fetched <= '0;
      ifu_perf_dropped <= '0;
    end else begin
      ifu_perf_fetched <= ifu_perf_fetched + 32'(pop);
      ifu_perf_dropped <= ifu_perf_dropped + 32'(rsp_drop)
                          + (redirect ? 32'(fifo_count) - 32'd1 : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed bench for ifu_fetch_unit with an in-order, 1-cycle-latency imem model.
module tb_ifu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [1:0]  sel;
  logic        branch, flush;
  logic [31:0] branch_addr, jal_addr, jalr_addr;
  logic [1:0]  hazard;
  logic [31:0] inst, pc;
  logic        stall;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  logic        rsp_hold;
  logic [31:0] mq[$];
  logic [31:0] acc_log[$];
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  ifu_fetch_unit #(
    .DataWidth   (32),
    .RESET_VECTOR(32'h0000_0000),
    .FB_DEPTH    (2)
  ) dut (
    .brq_clk        (clk),
    .brq_rst        (rst),
    .imem_req_valid (req_valid),
    .imem_req_ready (req_ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .idu_next_pc_sel(sel),
    .idu_branch     (branch),
    .idu_flush      (flush),
    .idu_branch_addr(branch_addr),
    .idu_jal_addr   (jal_addr),
    .idu_jalr_addr  (jalr_addr),
    .hazard_stall   (hazard),
    .ifu_fetch_inst (inst),
    .ifu_pc         (pc),
    .ifu_stall      (stall)
`ifdef IFU_PERF_CNT_EN
    ,
    .ifu_perf_fetched(perf_fetched),
    .ifu_perf_dropped(perf_dropped)
`endif
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // imem: decide the response for the coming edge, then record this cycle's accept.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end else begin
      if (!rsp_hold && mq.size() > 0) begin
        rsp_valid = 1'b1;
        rsp_data  = mdata(mq.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end
      if (req_valid && req_ready) begin
        mq.push_back(req_addr);
        acc_log.push_back(req_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    req_ready = 1'b0; hazard = 2'b00; flush = 1'b0; rsp_hold = 1'b0;
    sel = 2'b00; branch = 1'b0;
    repeat (8) tick();
  endtask

  // Leaves one instruction held at the head and one request in flight with its response withheld.
  task automatic setup_head_inflight();
    bit found = 0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (!stall) found = 1;
    end
    total++;
    if (!found) $display("FAIL setup_head: no instruction reached the head");
    else passed++;
    hazard = 2'b01; rsp_hold = 1'b1; req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++;
    if (req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", req_valid); else passed++;
    total++;
    if (stall !== 1'b1) $display("FAIL reset_stall: got %b want 1", stall); else passed++;
    total++;
    if (inst !== 32'h13) $display("FAIL reset_inst: got %h want 00000013", inst); else passed++;
    total++;
    if (pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc); else passed++;
`ifdef IFU_PERF_CNT_EN
    total++;
    if ({perf_fetched, perf_dropped} !== 64'h0)
      $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetched, perf_dropped);
    else passed++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_req_hold();
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({req_valid, req_addr, stall, inst} !== {1'b1, 32'h0, 1'b1, 32'h13})
        $display("FAIL req_hold[%0d]: valid=%b addr=%h stall=%b inst=%h want 1/00000000/1/00000013",
                 i, req_valid, req_addr, stall, inst);
      else passed++;
    end
  endtask

  task automatic test_sequential();
    logic [31:0] seen[$];
    bit found = 0;
    req_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (!stall) begin
        seen.push_back(pc);
        total++;
        if (inst !== mdata(pc)) $display("FAIL seq_inst: pc=%h got %h want %h", pc, inst, mdata(pc));
        else passed++;
        if (pc == 32'h8) begin
          hazard = 2'b01;
          found  = 1;
        end
      end
    end
    total++;
    if (!found || seen.size() != 3 || seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8)
      $display("FAIL seq_order: got %p want 0,4,8", seen);
    else passed++;
    total++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8)
      $display("FAIL seq_req_addrs: got %p want 0,4,8,...", acc_log);
    else passed++;
  endtask

  task automatic test_hazard();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({pc, inst, stall} !== {32'h8, mdata(32'h8), 1'b0})
        $display("FAIL hazard_hold[%0d]: pc=%h inst=%h stall=%b want 00000008/%h/0", i, pc, inst, stall, mdata(32'h8));
      else passed++;
    end
    total++;
    if (acc_log.size() != 4 || acc_log[3] !== 32'hC)
      $display("FAIL hazard_credit: got %0d requests %p want 4 ending at 0000000c", acc_log.size(), acc_log);
    else passed++;
    hazard = 2'b00;
    tick();
    total++;
    if ({pc, inst, stall} !== {32'hC, mdata(32'hC), 1'b0})
      $display("FAIL hazard_resume: pc=%h inst=%h stall=%b want 0000000c/%h/0", pc, inst, stall, mdata(32'hC));
    else passed++;
  endtask

  task automatic test_flush_jal();
    logic [31:0] seen[$];
    settle();
    setup_head_inflight();
    flush = 1'b1; sel = 2'b10; jal_addr = 32'h100;
    #1;
    total++;
    if (req_valid !== 1'b0) $display("FAIL jal_redirect_valid: got %b want 0", req_valid); else passed++;
    tick();
    flush = 1'b0; hazard = 2'b00; req_ready = 1'b1; rsp_hold = 1'b0;
    #1;
    total++;
    if ({req_valid, req_addr, stall} !== {1'b1, 32'h100, 1'b1})
      $display("FAIL jal_next_req: valid=%b addr=%h stall=%b want 1/00000100/1", req_valid, req_addr, stall);
    else passed++;
    for (int i = 0; i < 12 && seen.size() < 2; i++) begin
      tick();
      if (!stall) begin
        seen.push_back(pc);
        total++;
        if (inst !== mdata(pc)) $display("FAIL jal_inst: pc=%h got %h want %h", pc, inst, mdata(pc));
        else passed++;
      end
    end
    total++;
    if (seen.size() != 2 || seen[0] !== 32'h100 || seen[1] !== 32'h104)
      $display("FAIL jal_first_pcs: got %p want 100,104", seen);
    else passed++;
  endtask

  task automatic test_flush_jalr();
    bit found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (!stall) found = 1;
      else tick();
    end
    flush = 1'b1; sel = 2'b11; jalr_addr = 32'h203;
    #1;
    total++;
    if (!found || req_valid !== 1'b0)
      $display("FAIL jalr_redirect_valid: head=%b valid=%b want head and valid 0", found, req_valid);
    else passed++;
    tick();
    flush = 1'b0;
    #1;
    total++;
    if ({req_valid, req_addr} !== {1'b1, 32'h200})
      $display("FAIL jalr_next_req: valid=%b addr=%h want 1/00000200", req_valid, req_addr);
    else passed++;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (!stall) found = 1;
    end
    total++;
    if (!found || pc !== 32'h200) $display("FAIL jalr_first_pc: got %h found=%b want 00000200", pc, found);
    else passed++;
  endtask

  task automatic test_flush_branch();
    bit found = 0;
    hazard = 2'b01;
    repeat (6) tick();
    flush = 1'b1; sel = 2'b01; branch = 1'b1; branch_addr = 32'h40;
    tick();
    flush = 1'b0; hazard = 2'b00; branch = 1'b0;
    #1;
    total++;
    if ({stall, req_valid, req_addr} !== {1'b1, 1'b1, 32'h40})
      $display("FAIL br_clear: stall=%b valid=%b addr=%h want 1/1/00000040", stall, req_valid, req_addr);
    else passed++;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (!stall) found = 1;
    end
    total++;
    if (!found || pc !== 32'h40 || inst !== mdata(32'h40))
      $display("FAIL br_first_pc: pc=%h inst=%h found=%b want 00000040/%h", pc, inst, found, mdata(32'h40));
    else passed++;
  endtask

  task automatic test_reset_mid_drain();
    bit found = 0;
    settle();
    setup_head_inflight();
    flush = 1'b1; sel = 2'b10; jal_addr = 32'h300;
    tick();
    flush = 1'b0; hazard = 2'b00; req_ready = 1'b0;
    #1;
    total++;
    if ({req_valid, req_addr} !== {1'b1, 32'h300})
      $display("FAIL drain_req: valid=%b addr=%h want 1/00000300", req_valid, req_addr);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({req_valid, stall, inst, pc} !== {1'b0, 1'b1, 32'h13, 32'h0})
      $display("FAIL midrst_outputs: valid=%b stall=%b inst=%h pc=%h want 0/1/00000013/00000000",
               req_valid, stall, inst, pc);
    else passed++;
`ifdef IFU_PERF_CNT_EN
    total++;
    if ({perf_fetched, perf_dropped} !== 64'h0)
      $display("FAIL midrst_perf: got %h/%h want 0/0", perf_fetched, perf_dropped);
    else passed++;
`endif
    repeat (2) tick();
    rst = 1'b0; rsp_hold = 1'b0; req_ready = 1'b1;
    #1;
    total++;
    if ({req_valid, req_addr} !== {1'b1, 32'h0})
      $display("FAIL midrst_req: valid=%b addr=%h want 1/00000000", req_valid, req_addr);
    else passed++;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (!stall) found = 1;
    end
    total++;
    if (!found || pc !== 32'h0 || inst !== mdata(32'h0))
      $display("FAIL midrst_first_pc: pc=%h inst=%h found=%b want 00000000/%h", pc, inst, found, mdata(32'h0));
    else passed++;
  endtask

  initial begin
    req_ready = 1'b0; rsp_hold = 1'b0; sel = 2'b00; branch = 1'b0; flush = 1'b0;
    branch_addr = '0; jal_addr = '0; jalr_addr = '0; hazard = 2'b00;
    test_reset();
    test_req_hold();
    test_sequential();
    test_hazard();
    test_flush_jal();
    test_flush_jalr();
    test_flush_branch();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
